// File: rtl/seg_scan_if.sv
// Scan bus between a multiplexed 7-segment display driver and a receiver.
// The driver owns the active-low digit selects and the active-high segment lines.
interface seg_scan_if;
    logic [7:0] com;
    logic [6:0] num_data;

    modport master (
        output com,
        output num_data
    );

    modport slave (
        input com,
        input num_data
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the 8-digit BCD score from a multiplexed 7-segment scan bus.
// Pipeline: 2-flop sync -> stability filter -> classify/decode -> frame assembly FSM.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   scan,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [3:0]  digit5,
    output logic [3:0]  digit6,
    output logic [3:0]  digit7,
    output logic [3:0]  digit8,
    output logic [31:0] score_bcd,
    output logic        frame_valid,
    output logic        frame_strobe,
    output logic        seg_err,
    output logic        com_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [3:0]        STAB       = 4'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    // Returns {legal, bcd}; anything outside the ten digit glyphs is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = {1'b1, 4'd0};
            7'h30:   r = {1'b1, 4'd1};
            7'h6D:   r = {1'b1, 4'd2};
            7'h79:   r = {1'b1, 4'd3};
            7'h33:   r = {1'b1, 4'd4};
            7'h5B:   r = {1'b1, 4'd5};
            7'h5F:   r = {1'b1, 4'd6};
            7'h70:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h7B:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [7:0] com_s1_q, com_s2_q, com_prev_q, acc_com_q;
    logic [6:0] seg_s1_q, seg_s2_q, seg_prev_q, acc_seg_q;
    logic [3:0] stab_cnt_q, stab_cnt_d;
    logic       acc_valid_q, acc_valid_d;
    logic       pair_changed_s;

    // Stability count of the synchronized pair; a pair fires exactly once when it reaches STAB.
    always_comb begin
        pair_changed_s = ({com_s2_q, seg_s2_q} != {com_prev_q, seg_prev_q});
        stab_cnt_d     = stab_cnt_q;
        if (pair_changed_s) begin
            stab_cnt_d = 4'd1;
        end else if (stab_cnt_q < STAB) begin
            stab_cnt_d = stab_cnt_q + 4'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        acc_valid_d = (stab_cnt_d == STAB) && (pair_changed_s || (stab_cnt_q != STAB));
    end

    // Input synchronizer, previous-sample history and accepted-pair register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_s1_q    <= 8'hFF;
            com_s2_q    <= 8'hFF;
            com_prev_q  <= 8'hFF;
            seg_s1_q    <= 7'h00;
            seg_s2_q    <= 7'h00;
            seg_prev_q  <= 7'h00;
            stab_cnt_q  <= 4'd0;
            acc_valid_q <= 1'b0;
            acc_com_q   <= 8'hFF;
            acc_seg_q   <= 7'h00;
        end else begin
            com_s1_q    <= scan.com;
            seg_s1_q    <= scan.num_data;
            com_s2_q    <= com_s1_q;
            seg_s2_q    <= seg_s1_q;
            com_prev_q  <= com_s2_q;
            seg_prev_q  <= seg_s2_q;
            stab_cnt_q  <= stab_cnt_d;
            acc_valid_q <= acc_valid_d;
            acc_com_q   <= com_s2_q;
            acc_seg_q   <= seg_s2_q;
        end
    end

    state_e            state_q;
    logic [7:0]        seen_q;
    logic [7:0][3:0]   shadow_q;
    logic [7:0][3:0]   digits_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              frame_valid_q, frame_strobe_q, seg_err_q, com_err_q;

    logic [4:0]        dec_s;
    logic [2:0]        pos_s;
    logic              wr_s, seg_bad_s, com_bad_s, full_s, timeout_s;
    logic [7:0]        wr_mask_s, seen_wr_s;
    logic [7:0][3:0]   shadow_wr_s;

    // Classify the accepted pair and form the post-write shadow/seen view.
    always_comb begin
        dec_s     = seg_decode(acc_seg_q);
        pos_s     = onehot_index(~acc_com_q);
        wr_s      = 1'b0;
        seg_bad_s = 1'b0;
        com_bad_s = 1'b0;
        wr_mask_s = 8'h00;
        if (!acc_valid_q) begin
            wr_s = 1'b0;
        end else if ((acc_com_q == 8'hFF) || (acc_com_q == 8'h00)) begin
            wr_s = 1'b0;
        end else if (!is_onehot(~acc_com_q)) begin
            com_bad_s = 1'b1;
        end else if (!dec_s[4]) begin
            seg_bad_s = 1'b1;
        end else begin
            wr_s      = 1'b1;
            wr_mask_s = 8'h01 << pos_s;
        end

        shadow_wr_s = shadow_q;
        if (wr_s) begin
            shadow_wr_s[pos_s] = dec_s[3:0];
        end else begin
            shadow_wr_s = shadow_q;
        end
        seen_wr_s = seen_q | wr_mask_s;
        full_s    = (seen_wr_s == 8'hFF);
        timeout_s = !wr_s && (idle_cnt_q == IDLE_LAST);
    end

    // Frame assembly FSM with registered outputs; a commit always beats a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seen_q         <= 8'h00;
            shadow_q       <= '0;
            digits_q       <= '0;
            idle_cnt_q     <= '0;
            frame_valid_q  <= 1'b0;
            frame_strobe_q <= 1'b0;
            seg_err_q      <= 1'b0;
            com_err_q      <= 1'b0;
        end else begin
            seg_err_q      <= seg_bad_s;
            com_err_q      <= com_bad_s;
            frame_strobe_q <= 1'b0;
            shadow_q       <= shadow_wr_s;

            if (wr_s) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end else begin
                idle_cnt_q <= idle_cnt_q;
            end

            if (full_s) begin
                digits_q       <= shadow_wr_s;
                frame_strobe_q <= 1'b1;
                frame_valid_q  <= 1'b1;
                seen_q         <= 8'h00;
                state_q        <= ST_COMMIT;
            end else if (timeout_s) begin
                seen_q        <= 8'h00;
                frame_valid_q <= 1'b0;
                state_q       <= ST_IDLE;
            end else begin
                seen_q <= seen_wr_s;
                case (state_q)
                    ST_IDLE:    state_q <= wr_s ? ST_COLLECT : ST_IDLE;
                    ST_COLLECT: state_q <= ST_COLLECT;
                    ST_COMMIT:  state_q <= wr_s ? ST_COLLECT : ST_IDLE;
                    default:    state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign digit1       = digits_q[0];
    assign digit2       = digits_q[1];
    assign digit3       = digits_q[2];
    assign digit4       = digits_q[3];
    assign digit5       = digits_q[4];
    assign digit6       = digits_q[5];
    assign digit7       = digits_q[6];
    assign digit8       = digits_q[7];
    assign score_bcd    = digits_q;
    assign frame_valid  = frame_valid_q;
    assign frame_strobe = frame_strobe_q;
    assign seg_err      = seg_err_q;
    assign com_err      = com_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan patterns and checks recovered frames,
// error pulses, timeout and reset behaviour against hand-computed values.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    seg_scan_if  bus();
    logic [3:0]  digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;
    logic [31:0] score_bcd;
    logic        frame_valid, frame_strobe, seg_err, com_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int strobe_cnt  = 0;
    int seg_err_cnt = 0;
    int com_err_cnt = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(2), .TIMEOUT(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan         (bus),
        .digit1       (digit1),
        .digit2       (digit2),
        .digit3       (digit3),
        .digit4       (digit4),
        .digit5       (digit5),
        .digit6       (digit6),
        .digit7       (digit7),
        .digit8       (digit8),
        .score_bcd    (score_bcd),
        .frame_valid  (frame_valid),
        .frame_strobe (frame_strobe),
        .seg_err      (seg_err),
        .com_err      (com_err)
    );

    // Pulse counters sampled on the inactive edge; a 1-cycle pulse adds exactly 1.
    always @(negedge clk) begin
        if (frame_strobe) strobe_cnt++;
        if (seg_err)      seg_err_cnt++;
        if (com_err)      com_err_cnt++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'h7E;
            4'd1: seg_of = 7'h30;
            4'd2: seg_of = 7'h6D;
            4'd3: seg_of = 7'h79;
            4'd4: seg_of = 7'h33;
            4'd5: seg_of = 7'h5B;
            4'd6: seg_of = 7'h5F;
            4'd7: seg_of = 7'h70;
            4'd8: seg_of = 7'h7F;
            4'd9: seg_of = 7'h7B;
            default: seg_of = 7'h00;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [6:0] s, input int n);
        bus.com      = c;
        bus.num_data = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_digit(input int k, input logic [3:0] d);
        logic [7:0] c;
        c = ~(8'h01 << (k - 1));
        drive(c, seg_of(d), 2);
    endtask

    task automatic scan_range(input logic [31:0] bcd, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_digit(k, bcd[4*(k-1) +: 4]);
        drive(8'hFF, 7'h00, 12);
    endtask

    initial begin
        int s0, e0, c0;
        logic [31:0] v;

        rst          = 1'b1;
        bus.com      = 8'hFF;
        bus.num_data = 7'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_score",  score_bcd, 32'h0);
        check_eq("rst_valid",  {31'd0, frame_valid}, 32'd0);
        check_eq("rst_strobe", {31'd0, frame_strobe}, 32'd0);
        check_eq("rst_errs",   {30'd0, seg_err, com_err}, 32'd0);
        rst = 1'b0;

        // Blank pattern: all digit selects low, no segments.
        s0 = strobe_cnt; e0 = seg_err_cnt; c0 = com_err_cnt;
        drive(8'h00, 7'h00, 50);
        drive(8'hFF, 7'h00, 4);
        check_eq("blank_strobe", strobe_cnt - s0, 0);
        check_eq("blank_errs",   (seg_err_cnt - e0) + (com_err_cnt - c0), 0);
        check_eq("blank_score",  score_bcd, 32'h0);

        // Plain scan of 00000123.
        s0 = strobe_cnt; e0 = seg_err_cnt;
        scan_range(32'h00000123, 1, 8);
        check_eq("t1_strobe", strobe_cnt - s0, 1);
        check_eq("t1_score",  score_bcd, 32'h00000123);
        check_eq("t1_valid",  {31'd0, frame_valid}, 32'd1);
        check_eq("t1_d1_d3",  {digit3, digit2, digit1}, {20'd0, 12'h123});
        check_eq("t1_seg_err", seg_err_cnt - e0, 0);

        // Illegal pattern on digit 3, then repair.
        v  = 32'h87654321;
        s0 = strobe_cnt; e0 = seg_err_cnt;
        send_digit(1, 4'd1);
        send_digit(2, 4'd2);
        drive(8'hFB, 7'h01, 2);
        for (int k = 4; k <= 8; k++) send_digit(k, v[4*(k-1) +: 4]);
        drive(8'hFF, 7'h00, 12);
        check_eq("t3_seg_err", seg_err_cnt - e0, 1);
        check_eq("t3_no_commit", strobe_cnt - s0, 0);
        for (int k = 1; k <= 8; k++) if (k != 3) send_digit(k, v[4*(k-1) +: 4]);
        drive(8'hFF, 7'h00, 12);
        check_eq("t3_rescan_no_commit", strobe_cnt - s0, 0);
        send_digit(3, 4'd3);
        drive(8'hFF, 7'h00, 12);
        check_eq("t3_repair_strobe", strobe_cnt - s0, 1);
        check_eq("t3_score", score_bcd, 32'h87654321);

        // Two digit selects active at once: error pulse, seen untouched.
        v  = 32'h24681357;
        s0 = strobe_cnt; c0 = com_err_cnt;
        drive(8'b0011_1111, 7'h7E, 2);
        drive(8'hFF, 7'h00, 8);
        check_eq("t4_com_err", com_err_cnt - c0, 1);
        scan_range(v, 1, 7);
        check_eq("t4_seven_no_commit", strobe_cnt - s0, 0);
        scan_range(v, 8, 8);
        check_eq("t4_strobe", strobe_cnt - s0, 1);
        check_eq("t4_score",  score_bcd, 32'h24681357);

        // Single-cycle glitches are filtered out.
        s0 = strobe_cnt; e0 = seg_err_cnt; c0 = com_err_cnt;
        send_digit(1, 4'd5);
        drive(8'hFE, 7'h7F, 1);
        drive(8'h3C, 7'h01, 1);
        for (int k = 2; k <= 8; k++) send_digit(k, 4'd5);
        drive(8'hFF, 7'h00, 12);
        check_eq("t5_glitch_strobe", strobe_cnt - s0, 1);
        check_eq("t5_glitch_score",  score_bcd, 32'h55555555);
        check_eq("t5_glitch_errs",   (seg_err_cnt - e0) + (com_err_cnt - c0), 0);

        // Partial frame then silence: timeout drops valid, digits hold.
        s0 = strobe_cnt;
        scan_range(32'h77777777, 1, 7);
        repeat (500) @(negedge clk);
        check_eq("t5_pre_timeout_valid", {31'd0, frame_valid}, 32'd1);
        repeat (600) @(negedge clk);
        check_eq("t5_timeout_valid", {31'd0, frame_valid}, 32'd0);
        check_eq("t5_timeout_hold",  score_bcd, 32'h55555555);
        scan_range(32'h77777777, 8, 8);
        check_eq("t5_partial_discarded", strobe_cnt - s0, 0);
        check_eq("t5_digit8_hold", {28'd0, digit8}, 32'd5);

        // Asynchronous reset in the middle of a frame.
        for (int k = 1; k <= 4; k++) send_digit(k, 4'd4);
        bus.com = 8'hFF;
        bus.num_data = 7'h00;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_score", score_bcd, 32'h0);
        check_eq("t6_rst_valid", {31'd0, frame_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = strobe_cnt;
        scan_range(32'h99999999, 5, 8);
        check_eq("t6_no_stale_commit", strobe_cnt - s0, 0);
        scan_range(32'h99999999, 1, 8);
        check_eq("t6_strobe", strobe_cnt - s0, 1);
        check_eq("t6_score",  score_bcd, 32'h99999999);
        check_eq("t6_valid",  {31'd0, frame_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
